text_console_ctrl: RTL and testbench

- Character-stream controller that owns the write side of the text-mode character buffer that the VGA draw path scans.
- Accepts ASCII bytes over a valid/ready handshake and tracks a cursor.
- Writes printable glyph codes into the buffer and handles control codes.
- Performs a hardware scroll (row copy plus last-row clear) when output runs off the bottom of the screen.
- Sits between the CPU/UART byte source and the dual-port character buffer; the display side reads the buffer independently.

---
 rtl/console_pkg.sv | 37 +++
 rtl/text_console_ctrl_if.sv | 30 +++
 rtl/cursor_blink.sv | 56 +++++
 rtl/text_console_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/console_pkg.sv
// ---------------------------------------------------------------------------
// console_pkg
//   Shared definitions for the text console write-side controller:
//   controller state encoding, special character codes, the default
//   display geometry of the 640x480 text mode (8x16 glyphs), and the
//   derived cursor/address widths.
// ---------------------------------------------------------------------------
package console_pkg;

    typedef enum logic [1:0] {
        CS_CLEAR     = 2'd0,
        CS_IDLE      = 2'd1,
        CS_SCR_COPY  = 2'd2,
        CS_SCR_CLEAR = 2'd3
    } console_state_t;

    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] CH_BS      = 8'h08;
    localparam logic [7:0] CH_FF      = 8'h0C;

    localparam logic [7:0] PRINT_LO   = 8'h20;
    localparam logic [7:0] PRINT_HI   = 8'h7E;

    // Existing display constants: 640/8 columns, 480/16 rows.
    localparam int DISP_COLS = 80;
    localparam int DISP_ROWS = 30;

    localparam int ROW_W = $clog2(DISP_ROWS);
    localparam int COL_W = $clog2(DISP_COLS);

    function automatic logic isPrintable(input logic [7:0] code);
        return (code >= PRINT_LO) && (code <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// ---------------------------------------------------------------------------
// text_console_ctrl_if
//   Byte-stream valid/ready channel feeding the text console controller.
//   Signals:
//     ch_valid  source -> console  byte on ch_data is valid
//     ch_data   source -> console  ASCII byte
//     ch_ready  console -> source  console accepts a byte this cycle
//   Modports:
//     master  the byte source (CPU / UART)
//     slave   the console controller
// ---------------------------------------------------------------------------
interface text_console_ctrl_if #(
    parameter int ASCII_SIZE = 8
);
    logic                  ch_valid;
    logic [ASCII_SIZE-1:0] ch_data;
    logic                  ch_ready;

    modport master (
        output ch_valid,
        output ch_data,
        input  ch_ready
    );

    modport slave (
        input  ch_valid,
        input  ch_data,
        output ch_ready
    );
endinterface

// File: rtl/cursor_blink.sv
// ---------------------------------------------------------------------------
// cursor_blink
//   Cursor blink timebase. Counts falling edges of vSync; after BLINK_FRAMES
//   of them the cursor visibility flips and the count restarts. A kick (an
//   accepted console byte) makes the cursor visible and restarts the count,
//   so the cursor never vanishes while text is streaming in.
//   Only built when CONSOLE_CURSOR_BLINK_EN is defined.
//   Ports:
//     clk_25M   in   pixel clock
//     rst       in   synchronous active-high reset
//     vSync     in   frame sync
//     kick      in   byte accepted this cycle
//     cursorOn  out  cursor visible
// ---------------------------------------------------------------------------
`ifdef CONSOLE_CURSOR_BLINK_EN
module cursor_blink #(
    parameter int BLINK_FRAMES = 32
) (
    input  logic clk_25M,
    input  logic rst,
    input  logic vSync,
    input  logic kick,
    output logic cursorOn
);
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

    logic             vSyncD;
    logic [CNT_W-1:0] frameCnt;
    logic             vFall;

    assign vFall = vSyncD & ~vSync;

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            vSyncD   <= 1'b0;
            frameCnt <= '0;
            cursorOn <= 1'b1;
        end else begin
            vSyncD <= vSync;
            // A kick wins over a coincident frame edge.
            if (kick) begin
                cursorOn <= 1'b1;
                frameCnt <= '0;
            end else if (vFall) begin
                if (frameCnt == LAST_FRAME) begin
                    cursorOn <= ~cursorOn;
                    frameCnt <= '0;
                end else begin
                    frameCnt <= frameCnt + 1'b1;
                end
            end
        end
    end
endmodule
`endif

// File: rtl/text_console_ctrl.sv
// ---------------------------------------------------------------------------
// text_console_ctrl
//   Owns the write side of the text-mode character buffer scanned by the VGA
//   draw path. Accepts ASCII bytes, writes printable glyphs at the cursor,
//   handles LF/CR/BS/FF, and scrolls the screen in hardware (row copy up by
//   one, then blank the last row) when output runs off the bottom.
//
//   Optional feature: define CONSOLE_CURSOR_BLINK_EN to blink the cursor from
//   the vSync timebase; otherwise cursor_on is constantly 1 and vSync unused.
//
//   Ports:
//     clk_25M               in   pixel clock, rising edge
//     rst                   in   synchronous active-high reset
//     chIf (slave)          -    byte stream: ch_valid / ch_data / ch_ready
//     buf_we                out  buffer write enable
//     buf_wrow / buf_wcol   out  buffer write address
//     buf_wdata             out  buffer write data
//     buf_rrow / buf_rcol   out  buffer read address (scroll copy)
//     buf_rdata             in   buffer read data, one cycle after address
//     vSync                 in   frame sync (blink timebase)
//     cursor_row/cursor_col out  cursor position
//     cursor_on             out  cursor visible this frame
// ---------------------------------------------------------------------------
module text_console_ctrl
    import console_pkg::*;
#(
    parameter int ASCII_SIZE   = 8,
    parameter int CHARS_HORZ   = DISP_COLS,
    parameter int CHARS_VERT   = DISP_ROWS,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                          clk_25M,
    input  logic                          rst,
    text_console_ctrl_if.slave            chIf,
    output logic                          buf_we,
    output logic [$clog2(CHARS_VERT)-1:0] buf_wrow,
    output logic [$clog2(CHARS_HORZ)-1:0] buf_wcol,
    output logic [ASCII_SIZE-1:0]         buf_wdata,
    output logic [$clog2(CHARS_VERT)-1:0] buf_rrow,
    output logic [$clog2(CHARS_HORZ)-1:0] buf_rcol,
    input  logic [ASCII_SIZE-1:0]         buf_rdata,
    input  logic                          vSync,
    output logic [$clog2(CHARS_VERT)-1:0] cursor_row,
    output logic [$clog2(CHARS_HORZ)-1:0] cursor_col,
    output logic                          cursor_on
);
    localparam int RW = $clog2(CHARS_VERT);
    localparam int CW = $clog2(CHARS_HORZ);

    localparam logic [RW-1:0] LAST_ROW      = RW'(CHARS_VERT - 1);
    localparam logic [CW-1:0] LAST_COL      = CW'(CHARS_HORZ - 1);
    localparam logic [RW-1:0] FIRST_SRC_ROW = RW'(1);
    localparam logic [ASCII_SIZE-1:0] BLANK = ASCII_SIZE'(SPACE_CHAR);

    localparam logic [1:0] CLEAR     = CS_CLEAR;
    localparam logic [1:0] IDLE      = CS_IDLE;
    localparam logic [1:0] SCR_COPY  = CS_SCR_COPY;
    localparam logic [1:0] SCR_CLEAR = CS_SCR_CLEAR;

    logic [1:0]    state;
    logic [RW-1:0] clrRow;
    logic [CW-1:0] clrCol;
    logic [RW-1:0] curRow;
    logic [CW-1:0] curCol;
    logic [RW-1:0] rdRow;
    logic [CW-1:0] rdCol;
    logic          rdDone;

    logic          vld_p1;
    logic [RW-1:0] wrRow_p1;
    logic [CW-1:0] wrCol_p1;

    logic          readyInt;
    logic          accept;
    logic [7:0]    code;
    logic          printable;
    logic          isLf;
    logic          isCr;
    logic          isBs;
    logic          isFf;
    logic          rowAdvance;

    // Reset gates the handshake and the write strobe combinationally so an
    // abort takes effect in the very cycle rst is high.
    assign readyInt   = !rst && (state == IDLE);
    assign accept     = chIf.ch_valid && readyInt;
    assign code       = 8'(chIf.ch_data);
    assign printable  = isPrintable(code);
    assign isLf       = (code == CH_LF);
    assign isCr       = (code == CH_CR);
    assign isBs       = (code == CH_BS);
    assign isFf       = (code == CH_FF);
    assign rowAdvance = accept && ((printable && (curCol == LAST_COL)) || isLf);

    assign chIf.ch_ready = readyInt;
    assign buf_rrow      = rdRow;
    assign buf_rcol      = rdCol;
    assign cursor_row    = curRow;
    assign cursor_col    = curCol;

    // Single write port mux: clear sweep, accepted glyph / backspace blank,
    // delayed scroll-copy write, or last-row blank.
    always_comb begin
        buf_we    = 1'b0;
        buf_wrow  = curRow;
        buf_wcol  = curCol;
        buf_wdata = BLANK;
        if (!rst) begin
            case (state)
                CLEAR: begin
                    buf_we   = 1'b1;
                    buf_wrow = clrRow;
                    buf_wcol = clrCol;
                end
                IDLE: begin
                    if (accept && printable) begin
                        buf_we    = 1'b1;
                        buf_wdata = chIf.ch_data;
                    end else if (accept && isBs && (curCol != '0)) begin
                        buf_we   = 1'b1;
                        buf_wcol = curCol - 1'b1;
                    end
                end
                SCR_COPY: begin
                    if (vld_p1) begin
                        buf_we    = 1'b1;
                        buf_wrow  = wrRow_p1;
                        buf_wcol  = wrCol_p1;
                        buf_wdata = buf_rdata;
                    end
                end
                SCR_CLEAR: begin
                    buf_we   = 1'b1;
                    buf_wrow = LAST_ROW;
                    buf_wcol = clrCol;
                end
                default: buf_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state  <= CLEAR;
            clrRow <= '0;
            clrCol <= '0;
            curRow <= '0;
            curCol <= '0;
            rdRow  <= '0;
            rdCol  <= '0;
            rdDone <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                CLEAR: begin
                    if (clrCol == LAST_COL) begin
                        clrCol <= '0;
                        if (clrRow == LAST_ROW) begin
                            clrRow <= '0;
                            curRow <= '0;
                            curCol <= '0;
                            state  <= IDLE;
                        end else begin
                            clrRow <= clrRow + 1'b1;
                        end
                    end else begin
                        clrCol <= clrCol + 1'b1;
                    end
                end
                IDLE: begin
                    if (rowAdvance) begin
                        curCol <= '0;
                        if (curRow == LAST_ROW) begin
                            // Cursor stays on the bottom row; the screen moves.
                            rdRow  <= FIRST_SRC_ROW;
                            rdCol  <= '0;
                            rdDone <= 1'b0;
                            state  <= SCR_COPY;
                        end else begin
                            curRow <= curRow + 1'b1;
                        end
                    end else if (accept) begin
                        if (printable) begin
                            curCol <= curCol + 1'b1;
                        end else if (isCr) begin
                            curCol <= '0;
                        end else if (isBs) begin
                            if (curCol != '0) begin
                                curCol <= curCol - 1'b1;
                            end
                        end else if (isFf) begin
                            clrRow <= '0;
                            clrCol <= '0;
                            state  <= CLEAR;
                        end
                    end
                end
                SCR_COPY: begin
                    if (!rdDone) begin
                        vld_p1 <= 1'b1;
                        if (rdCol == LAST_COL) begin
                            rdCol <= '0;
                            if (rdRow == LAST_ROW) begin
                                rdDone <= 1'b1;
                            end else begin
                                rdRow <= rdRow + 1'b1;
                            end
                        end else begin
                            rdCol <= rdCol + 1'b1;
                        end
                    end else begin
                        // This cycle drains the final copy write.
                        rdRow  <= '0;
                        rdCol  <= '0;
                        clrCol <= '0;
                        state  <= SCR_CLEAR;
                    end
                end
                SCR_CLEAR: begin
                    if (clrCol == LAST_COL) begin
                        clrCol <= '0;
                        state  <= IDLE;
                    end else begin
                        clrCol <= clrCol + 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // ---- read issue (p0) -> copy write (p1): destination is one row up ----
    always_ff @(posedge clk_25M) begin
        if ((state == SCR_COPY) && !rdDone) begin
            wrRow_p1 <= rdRow - 1'b1;
            wrCol_p1 <= rdCol;
        end
    end

`ifdef CONSOLE_CURSOR_BLINK_EN
    cursor_blink #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) uBlink (
        .clk_25M (clk_25M),
        .rst     (rst),
        .vSync   (vSync),
        .kick    (accept),
        .cursorOn(cursor_on)
    );
`else
    logic unusedBlinkInputs;
    assign unusedBlinkInputs = vSync ^ (BLINK_FRAMES == 0);
    assign cursor_on         = 1'b1;
`endif

endmodule

// File: tb/tb_text_console_ctrl.sv
module tb_text_console_ctrl;
    localparam int ROWS = 30;
    localparam int COLS = 80;
    localparam int LIMIT = 6000;

    logic       clk_25M = 1'b0;
    logic       rst;
    logic       vSync;
    logic       bufWe;
    logic [4:0] bufWrow, bufRrow, curRowO;
    logic [6:0] bufWcol, bufRcol, curColO;
    logic [7:0] bufWdata, bufRdata;
    logic       cursorOn;

    text_console_ctrl_if #(.ASCII_SIZE(8)) chIf ();

    text_console_ctrl #(
        .ASCII_SIZE(8), .CHARS_HORZ(COLS), .CHARS_VERT(ROWS), .BLINK_FRAMES(2)
    ) dut (
        .clk_25M(clk_25M), .rst(rst), .chIf(chIf),
        .buf_we(bufWe), .buf_wrow(bufWrow), .buf_wcol(bufWcol), .buf_wdata(bufWdata),
        .buf_rrow(bufRrow), .buf_rcol(bufRcol), .buf_rdata(bufRdata),
        .vSync(vSync), .cursor_row(curRowO), .cursor_col(curColO), .cursor_on(cursorOn)
    );

    always #20 clk_25M = ~clk_25M;

    // Dual-port character buffer: synchronous write, one-cycle read latency.
    logic [7:0] mem [ROWS][COLS];
    logic       memFill;
    int         weCount = 0;
    always @(posedge clk_25M) begin
        if (memFill) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[r][c] <= 8'hFF;
        end else if (bufWe) begin
            mem[bufWrow][bufWcol] <= bufWdata;
        end
        bufRdata <= mem[bufRrow][bufRcol];
        if (bufWe) weCount <= weCount + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: screen as a 2-D array ----------------
    logic [7:0] scr [ROWS][COLS];
    int refRow = 0;
    int refCol = 0;
    logic refOn = 1'b1;
    int refCnt = 0;

    task automatic modelClear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        refRow = 0;
        refCol = 0;
    endtask

    task automatic modelNewLine(output int busy);
        busy = 0;
        refCol = 0;
        if (refRow == ROWS - 1) begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r + 1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = 8'h20;
            busy = (ROWS - 1) * COLS + 1 + COLS;
        end else begin
            refRow++;
        end
    endtask

    task automatic modelByte(input logic [7:0] b, output logic eWe, output int eR, output int eC,
                             output logic [7:0] eD, output int eBusy);
        eWe = 1'b0; eR = refRow; eC = refCol; eD = 8'h20; eBusy = 0;
        refCnt = 0;
        refOn = 1'b1;
        if (b >= 8'h20 && b <= 8'h7E) begin
            eWe = 1'b1; eD = b;
            scr[refRow][refCol] = b;
            if (refCol == COLS - 1) modelNewLine(eBusy);
            else refCol++;
        end else if (b == 8'h0A) begin
            modelNewLine(eBusy);
        end else if (b == 8'h0D) begin
            refCol = 0;
        end else if (b == 8'h08) begin
            if (refCol > 0) begin
                refCol--;
                eWe = 1'b1; eC = refCol;
                scr[refRow][refCol] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            modelClear();
            eBusy = ROWS * COLS;
        end
    endtask

    // Offer one byte, sample the write port in the accept cycle, then count
    // the cycles until the controller is ready again.
    task automatic xfer(input logic [7:0] b, output logic sWe, output int sR, output int sC,
                        output logic [7:0] sD, output int busy);
        int guard = 0;
        @(negedge clk_25M);
        chIf.ch_valid = 1'b1;
        chIf.ch_data  = b;
        #1;
        while (!chIf.ch_ready && guard < LIMIT) begin
            @(negedge clk_25M); #1; guard++;
        end
        chk("accept_wait", chIf.ch_ready, 1);
        sWe = bufWe; sR = bufWrow; sC = bufWcol; sD = bufWdata;
        @(negedge clk_25M);
        chIf.ch_valid = 1'b0;
        busy = 0;
        #1;
        while (!chIf.ch_ready && busy < LIMIT) begin
            @(negedge clk_25M); #1; busy++;
        end
    endtask

    task automatic runByte(input logic [7:0] b, output int busy);
        logic eWe, sWe;
        int eR, eC, eBusy, sR, sC;
        logic [7:0] eD, sD;
        modelByte(b, eWe, eR, eC, eD, eBusy);
        xfer(b, sWe, sR, sC, sD, busy);
        chk("we", sWe, eWe);
        if (eWe) begin
            chk("wrow", sR, eR);
            chk("wcol", sC, eC);
            chk("wdata", sD, eD);
        end
        chk("busy", busy, eBusy);
        chk("cur_row", curRowO, refRow);
        chk("cur_col", curColO, refCol);
    endtask

    task automatic cmpScreen(input string tag);
        int nBad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[r][c] !== scr[r][c]) nBad++;
        chk({"screen_", tag}, nBad, 0);
    endtask

    task automatic vPulse();
        @(negedge clk_25M); vSync = 1'b1;
        repeat (2) @(negedge clk_25M);
        vSync = 1'b0;
        repeat (2) @(negedge clk_25M);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       expWe;
        int         expWr;
        int         expWc;
        logic [7:0] expWd;
        int         expRow;
        int         expCol;
    } vec_t;

    vec_t vecs [10];
    logic [7:0] discards [5];

    initial begin
        int n, busy, c0, sR, sC, pick;
        logic sWe, eWe;
        logic [7:0] sD, eD, b;
        int eR, eC, eBusy;

        vecs[0] = '{8'h48, 1'b1, 0, 0, 8'h48, 0, 1};
        vecs[1] = '{8'h69, 1'b1, 0, 1, 8'h69, 0, 2};
        vecs[2] = '{8'h08, 1'b1, 0, 1, 8'h20, 0, 1};
        vecs[3] = '{8'h0D, 1'b0, 0, 0, 8'h00, 0, 0};
        vecs[4] = '{8'h08, 1'b0, 0, 0, 8'h00, 0, 0};
        vecs[5] = '{8'h07, 1'b0, 0, 0, 8'h00, 0, 0};
        vecs[6] = '{8'h0A, 1'b0, 0, 0, 8'h00, 1, 0};
        vecs[7] = '{8'h7E, 1'b1, 1, 0, 8'h7E, 1, 1};
        vecs[8] = '{8'h1F, 1'b0, 0, 0, 8'h00, 1, 1};
        vecs[9] = '{8'h20, 1'b1, 1, 1, 8'h20, 1, 2};
        discards[0] = 8'h00; discards[1] = 8'h07; discards[2] = 8'h1B;
        discards[3] = 8'h7F; discards[4] = 8'h9A;

        // ---- reset state ----
        rst = 1'b1; memFill = 1'b1; vSync = 1'b0;
        chIf.ch_valid = 1'b0; chIf.ch_data = 8'h00;
        repeat (3) @(negedge clk_25M);
        memFill = 1'b0;
        #1;
        chk("rst_ready", chIf.ch_ready, 0);
        chk("rst_we", bufWe, 0);
        chk("rst_cur_row", curRowO, 0);
        chk("rst_cur_col", curColO, 0);
        chk("rst_rrow", bufRrow, 0);
        chk("rst_rcol", bufRcol, 0);
        chk("rst_cursor_on", cursorOn, 1);

        // ---- power-up clear ----
        @(negedge clk_25M);
        c0 = weCount;
        rst = 1'b0;
        n = 0;
        #1;
        chk("clr_first_we", bufWe, 1);
        while (!chIf.ch_ready && n < LIMIT) begin
            n++; @(negedge clk_25M); #1;
        end
        chk("clr_busy", n, ROWS * COLS);
        chk("clr_writes", weCount - c0, ROWS * COLS);
        modelClear();
        cmpScreen("clear");
        chk("clr_cur_row", curRowO, 0);
        chk("clr_cur_col", curColO, 0);

        // ---- table-driven single bytes ----
        for (int i = 0; i < 10; i++) begin
            modelByte(vecs[i].data, eWe, eR, eC, eD, eBusy);
            xfer(vecs[i].data, sWe, sR, sC, sD, busy);
            chk($sformatf("vec%0d_we", i), sWe, vecs[i].expWe);
            if (vecs[i].expWe) begin
                chk($sformatf("vec%0d_wrow", i), sR, vecs[i].expWr);
                chk($sformatf("vec%0d_wcol", i), sC, vecs[i].expWc);
                chk($sformatf("vec%0d_wdata", i), sD, vecs[i].expWd);
            end
            chk($sformatf("vec%0d_busy", i), busy, 0);
            chk($sformatf("vec%0d_row", i), curRowO, vecs[i].expRow);
            chk($sformatf("vec%0d_col", i), curColO, vecs[i].expCol);
        end
        cmpScreen("table");
        chk("hi_cell00", mem[0][0], 8'h48);

        // ---- form feed ----
        runByte(8'h0C, busy);
        chk("ff_busy", busy, ROWS * COLS);
        cmpScreen("ff");

        // ---- wrap and discard ----
        for (int i = 0; i < COLS; i++) runByte(8'($urandom_range(32, 126)), busy);
        chk("wrap_row", curRowO, 1);
        chk("wrap_col", curColO, 0);
        c0 = weCount;
        runByte(8'h0D, busy);
        runByte(8'h07, busy);
        chk("discard_writes", weCount - c0, 0);
        chk("discard_row", curRowO, 1);
        chk("discard_col", curColO, 0);

        // ---- fill rows, then scroll off the bottom ----
        while (refRow < ROWS - 1) begin
            for (int i = 0; i < 3; i++) runByte(8'($urandom_range(33, 126)), busy);
            runByte(8'h0A, busy);
        end
        for (int i = 0; i < 5; i++) runByte(8'($urandom_range(33, 126)), busy);
        runByte(8'h0A, busy);
        chk("scroll_busy", busy, 2321 + 80);
        chk("scroll_row", curRowO, ROWS - 1);
        chk("scroll_col", curColO, 0);
        cmpScreen("scroll");

        // ---- randomized stream ----
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 2)       b = 8'h0A;
            else if (pick < 4)  b = 8'h0D;
            else if (pick < 7)  b = 8'h08;
            else if (pick < 9)  b = discards[$urandom_range(0, 4)];
            else                b = 8'($urandom_range(32, 126));
            runByte(b, busy);
        end
        cmpScreen("random");

        // ---- reset in the middle of a scroll copy ----
        @(negedge clk_25M);
        chIf.ch_valid = 1'b1; chIf.ch_data = 8'h0A;
        #1;
        chk("mid_ready", chIf.ch_ready, 1);
        @(negedge clk_25M);
        chIf.ch_valid = 1'b0;
        repeat (500) @(negedge clk_25M);
        #1;
        chk("mid_copy_we", bufWe, 1);
        chk("mid_copy_wrow", bufWrow, 6);
        chk("mid_copy_wcol", bufWcol, 19);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", bufWe, 0);
        chk("mid_rst_ready", chIf.ch_ready, 0);
        @(negedge clk_25M);
        rst = 1'b0;
        #1;
        chk("restart_we", bufWe, 1);
        chk("restart_wrow", bufWrow, 0);
        chk("restart_wcol", bufWcol, 0);
        chk("restart_wdata", bufWdata, 8'h20);
        chk("restart_rrow", bufRrow, 0);
        @(negedge clk_25M);
        #1;
        chk("restart2_wrow", bufWrow, 0);
        chk("restart2_wcol", bufWcol, 1);
        n = 0;
        while (!chIf.ch_ready && n < LIMIT) begin
            n++; @(negedge clk_25M); #1;
        end
        chk("restart_busy", n, ROWS * COLS - 1);
        modelClear();
        refOn = 1'b1; refCnt = 0;
        cmpScreen("restart");
        chk("restart_cur_row", curRowO, 0);
        chk("restart_cur_col", curColO, 0);

        // ---- cursor blink ----
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 7) begin
                runByte(8'h0D, busy);
            end else begin
                vPulse();
`ifdef CONSOLE_CURSOR_BLINK_EN
                refCnt++;
                if (refCnt == 2) begin
                    refOn = ~refOn;
                    refCnt = 0;
                end
`endif
            end
            chk($sformatf("blink%0d", i), cursorOn, refOn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
